// File: rtl/next_pc_predict_if.sv
// Front-end bundle between the fetch/decode/execute pipeline and the next-PC unit.
// The pipeline side drives the master modport; next_pc_predict uses the slave modport.
interface next_pc_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  typedef logic [6:0] opcode_t;

  logic            stall;
  logic            dec_valid;
  opcode_t         dec_opcode;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_imm;
  logic            dec_pred_taken;
  logic            ex_valid;
  opcode_t         ex_opcode;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] pc;
  logic [1:0]      pc_src;
  logic            flush_fetch;
  logic            flush_decode;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output stall, dec_valid, dec_opcode, dec_pc, dec_imm,
           ex_valid, ex_opcode, ex_pc, ex_taken, ex_target, ex_pred_taken,
    input  dec_pred_taken, pc, pc_src, flush_fetch, flush_decode, mispredict_count
  );

  modport slave (
    input  stall, dec_valid, dec_opcode, dec_pc, dec_imm,
           ex_valid, ex_opcode, ex_pc, ex_taken, ex_target, ex_pred_taken,
    output dec_pred_taken, pc, pc_src, flush_fetch, flush_decode, mispredict_count
  );
endinterface

// File: rtl/next_pc_predict.sv
// Next-PC unit: owns the fetch PC, predicts branches in decode with a bimodal
// table of 2-bit counters, and recovers from execute-stage mispredictions.
module next_pc_predict #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BHT_ENTRIES  = 16,
  parameter int              CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  next_pc_predict_if.slave bus
);
  localparam int         IDX_W         = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    SRC_SEQ     = 2'd0,
    SRC_DEC     = 2'd1,
    SRC_EX_TGT  = 2'd2,
    SRC_EX_FALL = 2'd3
  } pc_src_e;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0] dec_idx, ex_idx;
  logic             dec_redirect, dec_pred;
  logic             ex_redirect, ex_is_branch;
  logic [XLEN-1:0]  dec_target, ex_dest;
  pc_src_e          ex_src, pc_src;

  assign dec_idx      = bus.dec_pc[IDX_W+1:2];
  assign ex_idx       = bus.ex_pc[IDX_W+1:2];
  assign ex_is_branch = bus.ex_valid && (bus.ex_opcode == OPCODE_BRANCH);

  // Decode-stage prediction reads the table before this cycle's execute update.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    dec_pred   = 1'b0;
    dec_target = bus.dec_pc + bus.dec_imm;
    if (!reset && bus.dec_valid && !bus.stall) begin
      if (bus.dec_opcode == OPCODE_JAL) begin
        dec_pred = 1'b1;
      end else if (bus.dec_opcode == OPCODE_BRANCH) begin
        dec_pred = bht_q[dec_idx][1];
      end
    end
    dec_redirect = dec_pred;
  end

  always_comb begin
    ex_redirect = 1'b0;
    ex_dest     = bus.ex_target;
    ex_src      = SRC_EX_TGT;
    if (!reset && bus.ex_valid) begin
      if (bus.ex_opcode == OPCODE_JALR) begin
        ex_redirect = 1'b1;
      end else if (bus.ex_opcode == OPCODE_BRANCH && (bus.ex_taken != bus.ex_pred_taken)) begin
        ex_redirect = 1'b1;
        if (!bus.ex_taken) begin
          ex_dest = bus.ex_pc + XLEN'(4);
          ex_src  = SRC_EX_FALL;
        end
      end
    end
  end

  // Priority: execute redirect, then stall hold, then decode redirect, then sequential.
  always_comb begin
    pc_d   = pc_q + XLEN'(4);
    pc_src = SRC_SEQ;
    if (reset) begin
      pc_d = RESET_VECTOR;
    end else if (ex_redirect) begin
      pc_d   = ex_dest;
      pc_src = ex_src;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (dec_redirect) begin
      pc_d   = dec_target;
      pc_src = SRC_DEC;
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q + CNT_W'(ex_redirect);
    bht_d = bht_q;
    if (ex_is_branch) begin
      if (bus.ex_taken && bht_q[ex_idx] != 2'b11) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else if (!bus.ex_taken && bht_q[ex_idx] != 2'b00) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pc_q               <= RESET_VECTOR;
      mispredict_count_q <= '0;
      // NOTE: the counter table is reset explicitly because prediction starts from a defined weakly-not-taken state.
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      pc_q               <= pc_d;
      mispredict_count_q <= mispredict_count_d;
      bht_q              <= bht_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_src           = pc_src;
  assign bus.dec_pred_taken   = dec_pred;
  assign bus.flush_decode     = ex_redirect;
  assign bus.flush_fetch      = ex_redirect || dec_redirect;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: doc/next_pc_predict.md
# next_pc_predict

Parametrised next-PC unit for the fetch/decode front end of the RV32 pipeline. It owns the architectural fetch PC register and selects each cycle between PC+4, a decode-stage predicted target, and an execute-stage correction. It generalises the fixed branch/jump PC-source choice: static-only selection becomes a configurable bimodal branch history table (BHT) of 2-bit saturating counters, with misprediction recovery and a misprediction counter.

## Interface
- XLEN, 32, PC/data width.
- RESET_VECTOR, 0, PC value loaded on reset.
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, ≥2; index = pc[log2(BHT_ENTRIES)+1:2].
- CNT_W, 16, width of mispredict counter.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  front end held; PC holds unless execute redirects.
- dec_valid  in  1  decode holds a valid instruction.
- dec_opcode  in  opcode_t  decode opcode.
- dec_pc  in  XLEN  PC of decode instruction.
- dec_imm  in  XLEN  sign-extended B/J immediate.
- dec_pred_taken  out  1  prediction for decode instruction; piped by the pipeline to ex_pred_taken.
- ex_valid  in  1  execute instruction valid; asserted exactly one cycle per instruction.
- ex_opcode  in  opcode_t  execute opcode.
- ex_pc  in  XLEN  PC of execute instruction.
- ex_taken  in  1  resolved branch_result.
- ex_target  in  XLEN  ALU-computed target.
- ex_pred_taken  in  1  prediction made in decode.
- pc  out  XLEN  current fetch PC (registered).
- pc_src  out  2  0 PC+4, 1 decode target, 2 execute target, 3 execute fall-through.
- flush_fetch  out  1  discard fetch-stage instruction.
- flush_decode  out  1  discard decode-stage instruction.
- mispredict_count  out  CNT_W  execute redirects since reset.

## Operation
- Decode prediction (combinational, only when dec_valid && !stall):
  - OPCODE_JAL: dec_pred_taken=1, dec redirect to dec_pc+dec_imm.
  - OPCODE_BRANCH: dec_pred_taken = BHT[idx(dec_pc)][1]; if 1, dec redirect to dec_pc+dec_imm.
  - Other opcodes, incl. OPCODE_JALR: dec_pred_taken=0, no dec redirect.
- Execute resolution (when ex_valid):
  - OPCODE_BRANCH and ex_taken≠ex_pred_taken: ex redirect; target ex_target if ex_taken, else ex_pc+4.
  - OPCODE_JALR: always ex redirect to ex_target.
  - OPCODE_JAL: no redirect; already taken in decode.
- Next-PC priority: ex redirect > stall (hold) > dec redirect > pc+4. pc_src reflects the winner. Hold reports pc_src=0.
- flush_decode = ex redirect. flush_fetch = ex redirect or dec redirect.
- BHT update: on ex_valid && OPCODE_BRANCH, counter idx(ex_pc) increments on ex_taken, else decrements. Counter saturates at 3/0. Update ignores stall.
- Same-index decode read and execute write in one cycle: decode sees the pre-update value.
- mispredict_count increments by 1 per ex redirect, JALR included, and wraps at 2^CNT_W.
- All adds are modulo 2^XLEN. No alignment checking.

## Timing
- Reset (synchronous, dominant over all other inputs): pc=RESET_VECTOR, all counters=2'b01 (weakly not-taken), mispredict_count=0. While reset is high, pc_src=0, flush_fetch=0, flush_decode=0, dec_pred_taken=0.
- pc updates on the clk edge after the selecting inputs. Decode redirect costs 1 bubble. Execute redirect costs 2 bubbles.
- BHT and mispredict_count updates are visible the cycle after the ex_valid cycle.
- Reset mid-redirect: the redirect is dropped and pc=RESET_VECTOR next cycle.

## Test plan
- Reset then 3 cycles with no valids -> pc: 0x0, 0x4, 0x8, 0xC. pc_src=0.
- Decode JAL, dec_pc=0x100, imm=0x40 -> pc=0x140 next cycle, pc_src=1, flush_fetch=1, dec_pred_taken=1.
- Branch at 0x20 resolved taken twice (ex_pred_taken=0, target 0x80) -> two execute redirects to 0x80, mispredict_count=2, counter=3. Next decode of 0x20 predicts taken to 0x20+imm.
- Predicted-taken branch resolves not-taken, ex_pc=0x20 -> pc=0x24, pc_src=3, flush_decode=1, flush_fetch=1.
- Same cycle: stall=1, decode JAL, ex JALR to 0x200 -> pc=0x200, pc_src=2. Stall alone with decode JAL -> pc held, no flush.
- CNT_W=2, five JALR redirects -> mispredict_count sequence 1, 2, 3, 0, 1. BHT_ENTRIES=2: branches at 0x0 and 0x8 alias to the same counter.
